// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned SERIAL_ADD_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fa.sv
// One-bit full adder cell shared by the serial adder controller.
module fa (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: sequences one full adder over WIDTH bits, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_ADD_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;

    fa u_fa (
        .A    (fa_a),
        .B    (fa_b),
        .Cin  (fa_cin),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // Next-state and datapath sequencing.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        fa_a    = a_q[cnt_q];
        fa_b    = b_q[cnt_q];
        fa_cin  = carry_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    cnt_d   = '0;
                    sh_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sh_d    = {fa_sum, sh_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                // Last bit: publish result; carry_q here is the carry into the MSB.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = sh_d;
                    cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Sum  = sum_q;
    assign Cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver predicts accepted operations,
// a negedge monitor checks done timing, busy, and held results.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A, B;
    logic         Cin;
    logic         busy, done, Cout;
    logic [W-1:0] Sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         Ovf;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           start_edge;
        int           done_edge;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;
    bit   rst_seen = 1'b0;
    int   next_accept = 0;

    logic [W-1:0] m_sum;
    logic         m_cout, m_ovf, prev_done;
    exp_t         mx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, expv);
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        rst_seen = rst_n;
    end

    // Monitor: reference state advances only on predicted completion or reset.
    always @(negedge clk) begin
        logic exp_busy, exp_done;
        if (!rst_seen) begin
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; prev_done = 1'b0;
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].start_edge <= edge_n) q.delete(i);
        end
        exp_busy = (q.size() > 0) && (edge_n >= q[0].start_edge) && (edge_n < q[0].done_edge);
        exp_done = (q.size() > 0) && (q[0].done_edge == edge_n);
        chk("done", 32'(done), 32'(exp_done));
        if (exp_done) begin
            mx = q.pop_front();
            m_sum = mx.sum; m_cout = mx.cout; m_ovf = mx.ovf;
        end
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("sum", 32'(Sum), 32'(m_sum));
        chk("cout", 32'(Cout), 32'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", 32'(Ovf), 32'(m_ovf));
`endif
        chk("done_twice", 32'(prev_done && done), 32'(0));
        prev_done = done;
    end

    // Drive one cycle; predict acceptance from the timing rules alone.
    task automatic step(input logic r, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c);
        int   e;
        int   sg;
        exp_t x;
        @(negedge clk);
        rst_n = r; start = s; A = a; B = b; Cin = c;
        e = edge_n + 1;
        if (!r) begin
            next_accept = e + 1;
        end else if (s && e >= next_accept) begin
            {x.cout, x.sum} = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
            sg = int'($signed(a)) + int'($signed(b)) + int'(c);
            x.ovf = (sg > 127) || (sg < -128);
            x.start_edge = e;
            x.done_edge  = e + int'(W);
            q.push_back(x);
            next_accept = e + int'(W) + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; prev_done = 1'b0;

        // Reset held with start asserted: nothing may start.
        step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        idle(3);

        step(1'b1, 1'b1, 8'h0F, 8'h01, 1'b0);
        idle(W + 2);
        step(1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);
        idle(W + 2);
        step(1'b1, 1'b1, 8'h7F, 8'h00, 1'b1);
        idle(W + 2);

        // Start while busy must be ignored.
        step(1'b1, 1'b1, 8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'hAA, 8'h55, 1'b0);
        idle(W);

        // Start held continuously: accepted every W+1 cycles.
        for (int i = 0; i < 2 * W + 3; i++) step(1'b1, 1'b1, 8'h33 + 8'(i), 8'hC4, 1'(i));
        idle(W + 2);

        // Reset in the 4th RUN cycle aborts the operation.
        step(1'b1, 1'b1, 8'h5A, 8'hA5, 1'b1);
        idle(3);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        idle(W + 3);

        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 2) == 0),
                 8'($urandom), 8'($urandom), 1'($urandom));

        idle(W + 3);
        chk("drain_pending", 32'(q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
